mips_mainfsm: RTL and testbench
===============================

# mips_mainfsm

Main control state machine for the multicycle MIPS datapath. It drives the enable and select inputs of the datapath's enable-flops: `pcen` for the program counter, `irwrite` for the instruction register, `regwrite`, and `memwrite`. It also drives the mux selects and the ALU-op class that steer each instruction through fetch, decode, execute, memory and writeback. It is a Moore FSM: every control output is a function of the state register only, except `pcen`, which also depends on the ALU `zero` flag.

## Interface
Parameters: none (opcode and state encodings are fixed below).

- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; highest priority
- op  in  6  opcode field from instruction register (instr[31:26])
- zero  in  1  ALU zero flag (valid in BEQEX)
- pcen  out  1  PC register enable = pcwrite | (branch & zero)
- irwrite  out  1  instruction register enable
- memwrite  out  1  data memory write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- regwrite  out  1  register file write enable
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = PCJump
- aluop  out  2  00 = add, 01 = sub, 10 = use funct
- state  out  4  current state (debug/verification visibility)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are illegal.
- Opcodes:
  - LW = 100011
  - SW = 101011
  - RTYPE = 000000
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (LW or SW), RTYPEEX, BEQEX, ADDIEX, or JEX. Any other op → FETCH, so unsupported instructions execute as a no-op.
  - MEMADR → MEMRD (op = LW) or MEMWR (op = SW); any other op → FETCH.
  - MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
  - Illegal codes → FETCH on the next edge.
- Per-state outputs. Every output not listed is 0. `pcwrite` and `branch` are internal signals.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1
  - DECODE: alusrca=0, alusrcb=11, aluop=00
  - MEMADR: alusrca=1, alusrcb=10, aluop=00
  - MEMRD: iord=1
  - MEMWB: regdst=0, memtoreg=1, regwrite=1
  - MEMWR: iord=1, memwrite=1
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1
  - JEX: pcsrc=10, pcwrite=1
  - Illegal states: all outputs 0.
- `op` is sampled only in DECODE and MEMADR. The instruction register does not change then, because `irwrite` is 0.

## Timing
- Reset:
  - A clock edge with reset=1 forces state = FETCH regardless of the current state, including mid-instruction.
  - After that edge, outputs take FETCH values: pcen=1, irwrite=1, every other enable 0.
  - Reset held for several cycles keeps the FSM in FETCH. Reset has priority over all transitions.
- All outputs except `pcen` change only after a rising clock edge. `pcen` is combinational from `zero` in BEQEX and must settle within the same cycle.
- Cycles per instruction, counted from the FETCH cycle to the last state:
  - LW: 5
  - SW: 4
  - RTYPE: 4
  - ADDI: 4
  - BEQ: 3
  - J: 3
  - Unsupported op: 2 (FETCH, DECODE, then FETCH)
- Only one write enable (`regwrite`, `memwrite`, or `irwrite` together with `pcen`) is active in any state. `regwrite` and `memwrite` are never high in the same cycle.

## Test plan
- Reset: reset=1 for 2 edges, then release with op=000000 → state sequence 0,1,6,7,0. In state 7, regwrite=1 and regdst=1.
- LW: op=100011 → states 0,1,2,3,4,0. iord=1 in state 3. memtoreg=1 and regwrite=1 in state 4.
- SW: op=101011 → states 0,1,2,5,0. memwrite=1 only in state 5.
- BEQ:
  - zero=1 → state 8 has pcsrc=01, aluop=01, pcen=1.
  - zero=0 → pcen=0 in state 8. The next state is 0 in both cases.
- J and ADDI:
  - op=000010 → states 0,1,11,0, with pcsrc=10 and pcen=1 in state 11.
  - op=001000 → states 0,1,9,10,0, with alusrcb=10 in state 9 and regwrite=1, regdst=0 in state 10.
- Edge cases:
  - op=111111 → states 0,1,0.
  - reset=1 asserted in state 3 → state 0 after one edge.
  - Bench also asserts that regwrite and memwrite are never high in the same cycle, and that irwrite=1 only in state 0.

Source files
------------

// File: rtl/mips_mainfsm_if.sv
// mips_mainfsm_if: opcode/zero inputs and datapath control outputs of the main FSM
interface mips_mainfsm_if;
    logic [5:0] op;
    logic       zero;
    logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;
    modport master (output op, zero,
                    input pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
                          alusrca, alusrcb, pcsrc, aluop, state);
    modport slave  (input op, zero,
                    output pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
                           alusrca, alusrcb, pcsrc, aluop, state);
endinterface

// File: rtl/mips_mainfsm.sv
// mips_mainfsm: multicycle MIPS main control FSM; outputs registered alongside the state
module mips_mainfsm (
    input logic clk,
    input logic rst,
    mips_mainfsm_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
    } state_t;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RTYPE = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    state_t st, nx;
    logic [14:0] ctl;
    logic pcwrite, branch;
    // {pcwrite,branch,irwrite,memwrite,iord,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop}
    function automatic logic [14:0] ctl_of(state_t s);
        case (s)
            FETCH:          return 15'b1_0_1_0_0_0_0_0_0_01_00_00;
            DECODE:         return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
            MEMADR, ADDIEX: return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
            MEMRD:          return 15'b0_0_0_0_1_0_0_0_0_00_00_00;
            MEMWB:          return 15'b0_0_0_0_0_1_0_1_0_00_00_00;
            MEMWR:          return 15'b0_0_0_1_1_0_0_0_0_00_00_00;
            RTYPEEX:        return 15'b0_0_0_0_0_0_0_0_1_00_00_10;
            RTYPEWB:        return 15'b0_0_0_0_0_1_1_0_0_00_00_00;
            BEQEX:          return 15'b0_1_0_0_0_0_0_0_1_00_01_01;
            ADDIWB:         return 15'b0_0_0_0_0_1_0_0_0_00_00_00;
            JEX:            return 15'b1_0_0_0_0_0_0_0_0_00_10_00;
            default:        return 15'b0;
        endcase
    endfunction
    always_comb begin
        nx = FETCH;
        case (st)
            FETCH:   nx = DECODE;
            DECODE:  nx = (bus.op == LW || bus.op == SW) ? MEMADR :
                          (bus.op == RTYPE) ? RTYPEEX :
                          (bus.op == BEQ)   ? BEQEX :
                          (bus.op == ADDI)  ? ADDIEX :
                          (bus.op == J)     ? JEX : FETCH;
            MEMADR:  nx = (bus.op == LW) ? MEMRD : (bus.op == SW) ? MEMWR : FETCH;
            MEMRD:   nx = MEMWB;
            RTYPEEX: nx = RTYPEWB;
            ADDIEX:  nx = ADDIWB;
            default: nx = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        st  <= rst ? FETCH : nx;
        ctl <= ctl_of(rst ? FETCH : nx);
    end
    assign {pcwrite, branch, bus.irwrite, bus.memwrite, bus.iord, bus.regwrite, bus.regdst,
            bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop} = ctl;
    // Only pcen looks at zero, so a taken branch updates the PC within BEQEX
    assign bus.pcen  = pcwrite | (branch & bus.zero);
    assign bus.state = st;
endmodule

// File: tb/tb_mips_mainfsm.sv
// tb_mips_mainfsm: random instruction stream vs. a path-based reference model, plus directed literal checks
module tb_mips_mainfsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    mips_mainfsm_if bus();
    mips_mainfsm dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    int total = 0;
    int bad = 0;
    bit armed = 0;
    int path[$];
    int pi = 0;
    int mst = 0;

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, got, exp, $time);
        end
    endtask

    // Expected outputs follow directly from which phase of an instruction the model is in
    task automatic check_model();
        chk("state", int'(bus.state), mst);
        chk("irwrite", int'(bus.irwrite), int'(mst == 0));
        chk("memwrite", int'(bus.memwrite), int'(mst == 5));
        chk("iord", int'(bus.iord), int'(mst inside {3, 5}));
        chk("regwrite", int'(bus.regwrite), int'(mst inside {4, 7, 10}));
        chk("regdst", int'(bus.regdst), int'(mst == 7));
        chk("memtoreg", int'(bus.memtoreg), int'(mst == 4));
        chk("alusrca", int'(bus.alusrca), int'(mst inside {2, 6, 8, 9}));
        chk("alusrcb", int'(bus.alusrcb), mst == 0 ? 1 : mst == 1 ? 3 : mst inside {2, 9} ? 2 : 0);
        chk("pcsrc", int'(bus.pcsrc), mst == 8 ? 1 : mst == 11 ? 2 : 0);
        chk("aluop", int'(bus.aluop), mst == 6 ? 2 : mst == 8 ? 1 : 0);
        chk("pcen", int'(bus.pcen), int'(mst inside {0, 11} || (mst == 8 && bus.zero)));
        chk("rw_mw_excl", int'(bus.regwrite & bus.memwrite), 0);
    endtask

    task automatic model_step(input logic r, input logic [5:0] o);
        if (r) begin
            pi = 0;
            armed = 1;
        end else if (pi == 0) begin
            case (o)
                LW:      path = '{0, 1, 2, 3, 4};
                SW:      path = '{0, 1, 2, 5};
                RT:      path = '{0, 1, 6, 7};
                BEQ:     path = '{0, 1, 8};
                ADDI:    path = '{0, 1, 9, 10};
                J:       path = '{0, 1, 11};
                default: path = '{0, 1};
            endcase
            pi = 1;
        end else
            pi = (pi + 1 == path.size()) ? 0 : pi + 1;
        mst = (pi == 0) ? 0 : path[pi];
    endtask

    task automatic cyc(input logic r, input logic [5:0] o, input logic z);
        @(negedge clk);
        rst = r;
        bus.op = o;
        bus.zero = z;
        #1;
        if (armed) check_model();
        @(posedge clk);
        model_step(r, o);
        #1;
    endtask

    task automatic run_seq(input string n, input logic [5:0] o, input logic [19:0] seq, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            cyc(1'b0, o, 1'b0);
            chk(n, int'(bus.state), int'(seq[4*(cnt-1-i) +: 4]));
        end
    endtask

    logic [5:0] cur_op;
    logic [5:0] ops[7];

    initial begin
        bus.op = 6'b0;
        bus.zero = 1'b0;
        cyc(1'b1, RT, 1'b0);
        cyc(1'b1, RT, 1'b0);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_pcen", int'(bus.pcen), 1);
        chk("rst_irwrite", int'(bus.irwrite), 1);
        chk("rst_regwrite", int'(bus.regwrite), 0);
        chk("rst_memwrite", int'(bus.memwrite), 0);
        cyc(1'b0, RT, 1'b0);
        cyc(1'b0, RT, 1'b0);
        cyc(1'b0, RT, 1'b0);
        chk("rt_state7", int'(bus.state), 7);
        chk("rt_regwrite", int'(bus.regwrite), 1);
        chk("rt_regdst", int'(bus.regdst), 1);
        cyc(1'b0, RT, 1'b0);
        chk("rt_back", int'(bus.state), 0);
        run_seq("lw_seq", LW, 20'h12340, 5);
        run_seq("sw_seq", SW, 20'h00125, 3);
        chk("sw_memwrite", int'(bus.memwrite), 1);
        cyc(1'b0, SW, 1'b0);
        run_seq("j_seq", J, 20'h0001b, 2);
        chk("j_pcsrc", int'(bus.pcsrc), 2);
        chk("j_pcen", int'(bus.pcen), 1);
        cyc(1'b0, J, 1'b0);
        run_seq("addi_seq", ADDI, 20'h0019a, 3);
        chk("addi_regwrite", int'(bus.regwrite), 1);
        chk("addi_regdst", int'(bus.regdst), 0);
        cyc(1'b0, ADDI, 1'b0);
        for (int z = 1; z >= 0; z--) begin
            cyc(1'b0, BEQ, z[0]);
            cyc(1'b0, BEQ, z[0]);
            chk("beq_state", int'(bus.state), 8);
            chk("beq_pcen", int'(bus.pcen), z);
            chk("beq_pcsrc", int'(bus.pcsrc), 1);
            chk("beq_aluop", int'(bus.aluop), 1);
            cyc(1'b0, BEQ, z[0]);
            chk("beq_next", int'(bus.state), 0);
        end
        run_seq("bad_op", 6'b111111, 20'h00010, 2);
        run_seq("lw_to3", LW, 20'h00123, 3);
        cyc(1'b1, LW, 1'b0);
        chk("rst_mid", int'(bus.state), 0);
        ops = '{LW, SW, RT, BEQ, ADDI, J, 6'b0};
        cur_op = LW;
        for (int i = 0; i < 2000; i++) begin
            if (mst == 0) begin
                cur_op = ops[$urandom_range(0, 6)];
                if (cur_op == 6'b0 && $urandom_range(0, 1) == 1) cur_op = 6'($urandom);
            end
            cyc(1'($urandom_range(0, 39) == 0), cur_op, 1'($urandom));
        end
        cyc(1'b0, cur_op, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
